// File: rtl/gcd_arbiter_if.sv
// Requester and engine-side bus of gcd_arbiter. slave is the arbiter's view,
// master the surrounding requesters plus engine.
interface gcd_arbiter_if #(parameter int NREQ = 4);
  logic [NREQ-1:0]      req;
  logic [32*NREQ-1:0]   a_flat;
  logic [32*NREQ-1:0]   b_flat;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      done;
  logic [31:0]          result;
  logic                 busy;
  logic                 eng_start;
  logic [31:0]          eng_a;
  logic [31:0]          eng_b;
  logic                 eng_ready;
  logic                 eng_done_tick;
  logic [31:0]          eng_r;

  modport slave (
    input  req, a_flat, b_flat, eng_ready, eng_done_tick, eng_r,
    output gnt, done, result, busy, eng_start, eng_a, eng_b
  );

  modport master (
    output req, a_flat, b_flat, eng_ready, eng_done_tick, eng_r,
    input  gnt, done, result, busy, eng_start, eng_a, eng_b
  );
endinterface

// File: rtl/gcd_arbiter.sv
// Round-robin front end sharing one binary GCD engine among NREQ requesters.
// Define GCD_ARB_STATS_EN to add the job_count / busy_cycles counters.

module gcd_arb_lane #(
  parameter int IDX = 0,
  parameter int PW  = 3
) (
  input  logic          req,
  input  logic [PW-1:0] ptr,
  input  logic [PW-1:0] owner,
  input  logic          gnt_en,
  input  logic          done_en,
  output logic          hi,
  output logic          lo,
  output logic          gnt,
  output logic          done_set
);
  localparam logic [PW-1:0] ID = PW'(IDX);

  // hi marks requests at or above the rotating pointer; they win over wrapped ones
  assign lo       = req;
  assign hi       = req && (ID >= ptr);
  assign gnt      = gnt_en && (owner == ID);
  assign done_set = done_en && (owner == ID);
endmodule

module gcd_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = 3
) (
  input  logic          clk,
  input  logic          reset,
  gcd_arbiter_if.slave  bus
`ifdef GCD_ARB_STATS_EN
  ,
  output logic [15:0]   job_count,
  output logic [31:0]   busy_cycles
`endif
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPT, BYP} state_t;

  typedef struct packed {
    logic [31:0]   a;
    logic [31:0]   b;
    logic [PW-1:0] owner;
  } job_t;

  state_t                  state, state_nx;
  job_t                    job;
  logic [PW-1:0]           ptr, ptr_nx;
  logic [NREQ-1:0][31:0]   a_lane, b_lane;
  logic [NREQ-1:0]         hi, lo, gnt_l, done_set;
  logic                    gnt_en, done_en;
  logic                    found, take, byp;
  logic [PW-1:0]           win;
  logic [31:0]             win_a, win_b;
  logic [31:0]             result_q;
  logic [NREQ-1:0]         done_q;

  assign a_lane = bus.a_flat;
  assign b_lane = bus.b_flat;

  for (genvar g = 0; g < NREQ; g++) begin : g_lane
    gcd_arb_lane #(.IDX(g), .PW(PW)) u_lane (
      .req      (bus.req[g]),
      .ptr      (ptr),
      .owner    (job.owner),
      .gnt_en   (gnt_en),
      .done_en  (done_en),
      .hi       (hi[g]),
      .lo       (lo[g]),
      .gnt      (gnt_l[g]),
      .done_set (done_set[g])
    );
  end

  always_comb begin
    win   = '0;
    win_a = '0;
    win_b = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (hi[i] && !found) begin
        found = 1'b1;
        win   = PW'(i);
        win_a = a_lane[i];
        win_b = b_lane[i];
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (lo[i] && !found) begin
        found = 1'b1;
        win   = PW'(i);
        win_a = a_lane[i];
        win_b = b_lane[i];
      end
    end
  end

  assign take   = (|lo) && bus.eng_ready;
  // engine never terminates on a zero operand, so those jobs skip it
  assign byp    = (win_a == 32'd0) || (win_b == 32'd0);
  assign ptr_nx = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (take) state_nx = byp ? BYP : ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (bus.eng_done_tick) state_nx = CAPT;
      CAPT:    state_nx = IDLE;
      BYP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.eng_start = (state == ISSUE);
    gnt_en        = (state == ISSUE) || (state == BYP);
    done_en       = (state == CAPT)  || (state == BYP);
    bus.busy      = (state != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      job      <= '0;
      ptr      <= '0;
      result_q <= '0;
      done_q   <= '0;
    end else begin
      done_q <= done_set;
      if (state == IDLE && take) begin
        job.a     <= win_a;
        job.b     <= win_b;
        job.owner <= win;
        ptr       <= ptr_nx;
      end
      // engine r is valid in CAPT, one cycle after its done tick
      if (state == CAPT)     result_q <= bus.eng_r;
      else if (state == BYP) result_q <= job.a | job.b;
    end
  end

  assign bus.gnt    = gnt_l;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.eng_a  = job.a;
  assign bus.eng_b  = job.b;

`ifdef GCD_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      job_count   <= '0;
      busy_cycles <= '0;
    end else begin
      if ((|done_q) && (job_count != 16'hFFFF))          job_count   <= job_count + 16'd1;
      if ((state != IDLE) && (busy_cycles != 32'hFFFF_FFFF)) busy_cycles <= busy_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gcd_arbiter.sv
// Directed bench for gcd_arbiter with a behavioural binary GCD engine attached.
module tb_gcd_arbiter;
  localparam int NREQ  = 4;
  localparam int PW    = 3;
  localparam int BOUND = 300;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  gcd_arbiter_if #(.NREQ(NREQ)) ifc();

`ifdef GCD_ARB_STATS_EN
  logic [15:0] job_count;
  logic [31:0] busy_cycles;
`endif

  gcd_arbiter #(.NREQ(NREQ), .PW(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
`ifdef GCD_ARB_STATS_EN
    ,
    .job_count   (job_count),
    .busy_cycles (busy_cycles)
`endif
  );

  // behavioural engine: one Stein step per cycle, r valid the cycle after done tick
  logic        eng_run;
  logic        eng_hold;
  logic [31:0] ex, ey, er;
  logic [5:0]  ek;

  assign ifc.eng_ready     = !eng_run && !eng_hold;
  assign ifc.eng_done_tick = eng_run && (ex == ey);
  assign ifc.eng_r         = er;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      eng_run <= 1'b0; ex <= '0; ey <= '0; ek <= '0; er <= '0;
    end else if (!eng_run) begin
      if (ifc.eng_start) begin
        eng_run <= 1'b1; ex <= ifc.eng_a; ey <= ifc.eng_b; ek <= '0;
      end
    end else if (ex == ey) begin
      eng_run <= 1'b0; er <= ex << ek;
    end else if (!ex[0] && !ey[0]) begin
      ex <= ex >> 1; ey <= ey >> 1; ek <= ek + 6'd1;
    end else if (!ex[0]) ex <= ex >> 1;
    else if (!ey[0])     ey <= ey >> 1;
    else if (ex > ey)    ex <= ex - ey;
    else                 ey <= ey - ex;
  end

  int start_cnt = 0;
  always @(posedge clk) if (ifc.eng_start) start_cnt <= start_cnt + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    ifc.a_flat[32*i +: 32] = a;
    ifc.b_flat[32*i +: 32] = b;
  endtask

  task automatic wait_done(output int c);
    c = 0;
    while (ifc.done == '0 && c < BOUND) begin tick(); c++; end
  endtask

  task automatic wait_gnt(output int c);
    c = 0;
    while (ifc.gnt == '0 && c < BOUND) begin tick(); c++; end
  endtask

  task automatic test_reset();
    reset = 1'b1; ifc.req = '0; ifc.a_flat = '0; ifc.b_flat = '0; eng_hold = 1'b0;
    tick(); tick();
    n_chk++; if (ifc.gnt !== 4'b0) begin n_fail++; $display("FAIL reset_gnt: got %b want 0", ifc.gnt); end
    n_chk++; if (ifc.done !== 4'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", ifc.done); end
    n_chk++; if (ifc.result !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %0d want 0", ifc.result); end
    n_chk++; if (ifc.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", ifc.busy); end
    n_chk++; if (ifc.eng_start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b want 0", ifc.eng_start); end
    n_chk++; if ({ifc.eng_a, ifc.eng_b} !== 64'd0) begin n_fail++; $display("FAIL reset_eng_ab: got %0d/%0d want 0/0", ifc.eng_a, ifc.eng_b); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int c;
    set_op(0, 32'd12, 32'd18); ifc.req = 4'b0001;
    tick();
    n_chk++; if (ifc.gnt !== 4'b0001) begin n_fail++; $display("FAIL basic_gnt: got %b want 0001", ifc.gnt); end
    n_chk++; if (ifc.eng_start !== 1'b1) begin n_fail++; $display("FAIL basic_start: got %b want 1", ifc.eng_start); end
    n_chk++; if ({ifc.eng_a, ifc.eng_b} !== {32'd12, 32'd18}) begin n_fail++; $display("FAIL basic_eng_ab: got %0d/%0d want 12/18", ifc.eng_a, ifc.eng_b); end
    ifc.req = '0;
    wait_done(c);
    n_chk++; if (c >= BOUND) begin n_fail++; $display("FAIL basic_timeout: waited %0d cycles, limit %0d", c, BOUND); end
    n_chk++; if (ifc.done !== 4'b0001) begin n_fail++; $display("FAIL basic_done: got %b want 0001", ifc.done); end
    n_chk++; if (ifc.result !== 32'd6) begin n_fail++; $display("FAIL basic_result: got %0d want 6", ifc.result); end
    tick();
    n_chk++; if (ifc.done !== 4'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b want 0", ifc.done); end
    tick(); tick();
    n_chk++; if (ifc.result !== 32'd6) begin n_fail++; $display("FAIL basic_result_held: got %0d want 6", ifc.result); end
  endtask

  task automatic test_equal();
    set_op(2, 32'd40, 32'd40); ifc.req = 4'b0100;
    tick();
    n_chk++; if (ifc.gnt !== 4'b0100) begin n_fail++; $display("FAIL equal_gnt: got %b want 0100", ifc.gnt); end
    ifc.req = '0;
    tick();
    n_chk++; if (ifc.done !== 4'b0) begin n_fail++; $display("FAIL equal_done_t2: got %b want 0", ifc.done); end
    tick();
    n_chk++; if ({ifc.busy, ifc.done} !== 5'b10000) begin n_fail++; $display("FAIL equal_t3: got busy/done %b/%b want 1/0000", ifc.busy, ifc.done); end
    tick();
    n_chk++; if (ifc.done !== 4'b0100) begin n_fail++; $display("FAIL equal_done_t4: got %b want 0100", ifc.done); end
    n_chk++; if (ifc.result !== 32'd40) begin n_fail++; $display("FAIL equal_result: got %0d want 40", ifc.result); end
    n_chk++; if (ifc.busy !== 1'b0) begin n_fail++; $display("FAIL equal_idle: got busy %b want 0", ifc.busy); end
  endtask

  task automatic test_bypass();
    int s0;
    s0 = start_cnt;
    set_op(1, 32'd0, 32'd35); ifc.req = 4'b0010;
    tick();
    n_chk++; if ({ifc.gnt, ifc.eng_start} !== 5'b00100) begin n_fail++; $display("FAIL byp35_gnt: got gnt/start %b/%b want 0010/0", ifc.gnt, ifc.eng_start); end
    ifc.req = '0;
    tick();
    n_chk++; if (ifc.done !== 4'b0010) begin n_fail++; $display("FAIL byp35_done: got %b want 0010", ifc.done); end
    n_chk++; if (ifc.result !== 32'd35) begin n_fail++; $display("FAIL byp35_result: got %0d want 35", ifc.result); end
    set_op(3, 32'd0, 32'd0); ifc.req = 4'b1000;
    tick();
    n_chk++; if (ifc.gnt !== 4'b1000) begin n_fail++; $display("FAIL byp0_gnt: got %b want 1000", ifc.gnt); end
    ifc.req = '0;
    tick();
    n_chk++; if (ifc.done !== 4'b1000) begin n_fail++; $display("FAIL byp0_done: got %b want 1000", ifc.done); end
    n_chk++; if (ifc.result !== 32'd0) begin n_fail++; $display("FAIL byp0_result: got %0d want 0", ifc.result); end
    tick();
    n_chk++; if (start_cnt !== s0) begin n_fail++; $display("FAIL byp_no_start: got %0d starts want %0d", start_cnt, s0); end
  endtask

  task automatic test_back_to_back();
    int c;
    int ord[5]               = '{0, 1, 2, 3, 0};
    logic [31:0] exp_res[5]  = '{32'd12, 32'd12, 32'd36, 32'd12, 32'd12};
    logic [3:0] eg;
    for (int i = 0; i < NREQ; i++) set_op(i, 32'(48 * (i + 1)), 32'd36);
    ifc.req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      eg = 4'b0001 << ord[j];
      if (j == 0) begin
        wait_gnt(c);
        n_chk++; if (c >= BOUND) begin n_fail++; $display("FAIL rr_gnt_timeout: waited %0d cycles", c); end
      end else begin
        tick();
      end
      n_chk++; if (ifc.gnt !== eg) begin n_fail++; $display("FAIL rr_gnt_%0d: got %b want %b", j, ifc.gnt, eg); end
      if (j == 4) ifc.req = '0;
      wait_done(c);
      n_chk++; if (c >= BOUND) begin n_fail++; $display("FAIL rr_done_timeout_%0d: waited %0d cycles", j, c); end
      n_chk++; if ({ifc.done, ifc.gnt} !== {eg, 4'b0}) begin n_fail++; $display("FAIL rr_done_%0d: got done/gnt %b/%b want %b/0000", j, ifc.done, ifc.gnt, eg); end
      n_chk++; if (ifc.result !== exp_res[j]) begin n_fail++; $display("FAIL rr_result_%0d: got %0d want %0d", j, ifc.result, exp_res[j]); end
    end
    tick();
  endtask

  task automatic test_not_ready();
    int c;
    logic seen;
    eng_hold = 1'b1;
    set_op(2, 32'd9, 32'd6); ifc.req = 4'b0100;
    seen = 1'b0;
    repeat (3) begin tick(); seen = seen | (|ifc.gnt) | ifc.busy; end
    n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL notready_grant: got activity %b want 0", seen); end
    eng_hold = 1'b0;
    tick();
    n_chk++; if (ifc.gnt !== 4'b0100) begin n_fail++; $display("FAIL notready_gnt: got %b want 0100", ifc.gnt); end
    ifc.req = '0;
    wait_done(c);
    n_chk++; if (c >= BOUND) begin n_fail++; $display("FAIL notready_timeout: waited %0d cycles", c); end
    n_chk++; if (ifc.result !== 32'd3) begin n_fail++; $display("FAIL notready_result: got %0d want 3", ifc.result); end
    tick();
  endtask

  task automatic test_reset_mid();
    int c;
    logic seen;
    set_op(0, 32'h8000_0000, 32'd3); ifc.req = 4'b0001;
    tick();
    n_chk++; if (ifc.gnt !== 4'b0001) begin n_fail++; $display("FAIL rstmid_gnt: got %b want 0001", ifc.gnt); end
    ifc.req = '0;
    tick(); tick(); tick();
    n_chk++; if (ifc.busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy: got %b want 1", ifc.busy); end
    #2 reset = 1'b1;
    #1;
    n_chk++; if ({ifc.gnt, ifc.done, ifc.busy, ifc.eng_start, ifc.eng_a, ifc.eng_b} !== '0) begin
      n_fail++; $display("FAIL rstmid_outputs: got gnt %b done %b busy %b start %b a %0d b %0d want all 0",
                         ifc.gnt, ifc.done, ifc.busy, ifc.eng_start, ifc.eng_a, ifc.eng_b);
    end
    n_chk++; if (ifc.result !== 32'd0) begin n_fail++; $display("FAIL rstmid_result: got %0d want 0", ifc.result); end
    tick();
    reset = 1'b0;
    seen = 1'b0;
    repeat (4) begin tick(); seen = seen | (|ifc.done); end
    n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_done: got done activity %b want 0", seen); end
    ifc.req = 4'b0001;
    wait_gnt(c);
    n_chk++; if (ifc.gnt !== 4'b0001) begin n_fail++; $display("FAIL rstmid_regnt: got %b want 0001", ifc.gnt); end
    ifc.req = '0;
    wait_done(c);
    n_chk++; if (c >= BOUND) begin n_fail++; $display("FAIL rstmid_timeout: waited %0d cycles", c); end
    n_chk++; if ({ifc.done, ifc.result} !== {4'b0001, 32'd1}) begin n_fail++; $display("FAIL rstmid_result: got done %b result %0d want 0001/1", ifc.done, ifc.result); end
    tick();
  endtask

`ifdef GCD_ARB_STATS_EN
  task automatic test_stats();
    int c;
    reset = 1'b1; tick(); reset = 1'b0; tick();
    n_chk++; if ({job_count, busy_cycles} !== 48'd0) begin n_fail++; $display("FAIL stats_reset: got %0d/%0d want 0/0", job_count, busy_cycles); end
    set_op(0, 32'd40, 32'd40); ifc.req = 4'b0001; tick(); ifc.req = '0; wait_done(c); tick(); tick();
    set_op(1, 32'd0,  32'd5);  ifc.req = 4'b0010; tick(); ifc.req = '0; wait_done(c); tick(); tick();
    set_op(2, 32'd12, 32'd18); ifc.req = 4'b0100; tick(); ifc.req = '0; wait_done(c); tick(); tick();
    n_chk++; if (job_count !== 16'd3) begin n_fail++; $display("FAIL stats_jobs: got %0d want 3", job_count); end
    n_chk++; if (busy_cycles !== 32'd11) begin n_fail++; $display("FAIL stats_busy: got %0d want 11", busy_cycles); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_equal();
    test_bypass();
    test_back_to_back();
    test_not_ready();
    test_reset_mid();
`ifdef GCD_ARB_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
